circular_buffer_write_ctrl: RTL
===============================

Name: circular_buffer_write_ctrl

Overview:
Write-side controller for the column-organised circular input buffer. It is the producer counterpart of the read-pointer updater.
- Accepts PAR_WRITE data words per transfer over a valid/ready handshake and holds them in a one-deep stage register.
- Commits the staged words into the buffer memory at the wrapping write pointer.
- Tracks occupancy against read-side consumption (updateRP, PAR_READ words per pulse) and tells the read side when a full PAR_READ group is available.

Parameters:
COLUMNS, 32, number of buffer entries (columns)
PAR_WRITE, 1, words written per commit; must divide COLUMNS
PAR_READ, 4, words consumed per updateRP pulse; must divide COLUMNS and be <= COLUMNS
DATA_WIDTH, 8, bits per word

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  upstream has PAR_WRITE words
in_data  input  PAR_WRITE*DATA_WIDTH  words; word i at bits [i*DATA_WIDTH +: DATA_WIDTH], written to column write_ptr+i
in_ready  output  1  stage can accept this cycle
updateRP  input  1  read side consumed PAR_READ words this cycle
buf_wen  output  1  buffer write strobe (commit)
buf_waddr  output  clog2(COLUMNS)  base column of the commit (= write_ptr_out)
buf_wdata  output  PAR_WRITE*DATA_WIDTH  staged words
write_ptr_out  output  clog2(COLUMNS)  current write pointer
occupancy  output  clog2(COLUMNS)+1  committed, unconsumed words
full  output  1  occupancy > COLUMNS-PAR_WRITE (no room for a commit)
empty  output  1  occupancy == 0
read_avail  output  1  occupancy >= PAR_READ
underflow_err  output  1  sticky; an updateRP arrived with occupancy < PAR_READ

Behaviour:
- Reset: write_ptr_out=0, occupancy=0, stage empty, buf_wen=0, underflow_err=0. As a result in_ready=1, empty=1, full=0, read_avail=0.
- A reset asserted mid-operation discards any staged data; no commit occurs on the reset cycle.
- Accept: the transfer happens on an edge where in_valid && in_ready. in_data latches into the stage and stage_valid is set.
- Commit (combinational): commit = stage_valid && !full. buf_wen = commit, buf_waddr = write_ptr_out, buf_wdata = stage data. The memory samples these at the same edge.
- in_ready = !stage_valid || commit. This gives a pass-through stage: one accept plus one commit per cycle sustains full throughput.
- Latency: data accepted at edge N is committed at edge N+1 if not full. In-order, no loss, no duplication.
- Pointer update on commit: next = write_ptr_out + PAR_WRITE, computed clog2(COLUMNS)+1 bits wide. If next >= COLUMNS, write_ptr_out <= next - COLUMNS; otherwise write_ptr_out <= next.
- Occupancy update per edge, evaluated as one expression: occupancy += (commit ? PAR_WRITE : 0) - (read_ok ? PAR_READ : 0), where read_ok = updateRP && occupancy >= PAR_READ.
- Simultaneous commit and read_ok apply both deltas in the same cycle.
- full is evaluated on current occupancy only. A same-cycle updateRP does not unblock a commit; the commit happens the next cycle. This avoids a combinational path from updateRP.
- Illegal updateRP (occupancy < PAR_READ): occupancy is unchanged and underflow_err is set, staying set until rst.
- full, empty and read_avail are combinational decodes of registered occupancy.
- Overflow is impossible by construction: occupancy never exceeds COLUMNS.

Decomposition:
- Shared package buffer_pkg:
  - ptr_w(COLUMNS) = clog2(COLUMNS) and cnt_w = ptr_w+1 constants.
  - Wrap-add function (ptr, inc, COLUMNS), reusable by both the read and write pointer blocks.
- Natural sub-module: write_ptr_update, mirroring the read side. Inputs updateWP, clk, rst; output write_ptr_out; wrap arithmetic as above.
- The top level holds the stage register, handshake and occupancy counter.

Test Plan:
- Reset then idle → write_ptr_out=0, occupancy=0, empty=1, in_ready=1, buf_wen=0.
- Defaults, in_valid held high with data 0x10,0x11,… → buf_wen from the 2nd cycle onward at waddr 0,1,2,…; read_avail=1 once occupancy=4; full=1 at occupancy=32; in_ready drops after the stage fills; no word lost.
- Full buffer plus one staged word, single updateRP → occupancy 32→28, then 29 on the following edge when the staged word commits at waddr 0 (wrap 31→0).
- Steady state with in_valid=1 and updateRP every 4th cycle while occupancy=8 → occupancy oscillates within 8±3, returning to 8 after every 4-cycle period; pointer wraps correctly; buf_wdata matches the in_data order.
- updateRP with occupancy=2 → occupancy stays 2, underflow_err=1 and remains 1 until rst.
- rst asserted with stage_valid=1 and occupancy=12 → next cycle all state is at reset values and no buf_wen is issued.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared sizing helpers and wrap arithmetic for the circular input buffer.
// Both the read-pointer and the write-pointer blocks use it.
package buffer_pkg;

  // Pointer width for a buffer of 'columns' entries (at least 1 bit)
  function automatic int unsigned ptr_w(input int unsigned columns);
    return (columns > 1) ? $clog2(columns) : 1;
  endfunction

  // Counter width: one extra bit so a completely full buffer is representable
  function automatic int unsigned cnt_w(input int unsigned columns);
    return ptr_w(columns) + 1;
  endfunction

  // ptr + inc folded back into [0, columns); ptr and inc are each < columns
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned columns);
    int unsigned nxt;
    nxt = ptr + inc;
    return (nxt >= columns) ? (nxt - columns) : nxt;
  endfunction

endpackage

// File: rtl/circular_buffer_write_ctrl_write_ptr_update.sv
// Wrapping write pointer. It is the counterpart of the read-pointer updater.
// The pointer advances by PAR_WRITE columns on each updateWP.
// Ports: clk, rst (sync, active-high), updateWP (advance strobe),
//        write_ptr_out (current base column).
module write_ptr_update
  import buffer_pkg::*;
#(
  parameter int unsigned COLUMNS   = 32,
  parameter int unsigned PAR_WRITE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        updateWP,
  output logic [ptr_w(COLUMNS)-1:0]   write_ptr_out
);

  localparam int unsigned PTR_W = ptr_w(COLUMNS);

  logic [PTR_W-1:0] write_ptr_q;
  logic [PTR_W-1:0] write_ptr_d;

  // Next pointer
  always_comb begin
    write_ptr_d = write_ptr_q;
    if (updateWP) begin
      write_ptr_d = PTR_W'(wrap_add(32'(write_ptr_q), PAR_WRITE, COLUMNS));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) write_ptr_q <= '0;
    else     write_ptr_q <= write_ptr_d;
  end

  assign write_ptr_out = write_ptr_q;

endmodule

// File: rtl/circular_buffer_write_ctrl.sv
// Write-side controller for the column-organised circular input buffer.
// The block has a one-deep pass-through stage register. It commits staged words to
// the buffer at the wrapping write pointer. It also tracks occupancy against
// read-side consumption.
// Ports:
//   clk, rst                    clock, sync active-high reset
//   in_valid/in_data/in_ready   upstream handshake, PAR_WRITE words per transfer
//   updateRP                    read side consumed PAR_READ words
//   buf_wen/buf_waddr/buf_wdata buffer write port (combinational commit)
//   write_ptr_out, occupancy    current pointer / committed-unconsumed words
//   full, empty, read_avail     decodes of registered occupancy
//   underflow_err               sticky illegal-updateRP flag
module circular_buffer_write_ctrl
  import buffer_pkg::*;
#(
  parameter int unsigned COLUMNS    = 32,
  parameter int unsigned PAR_WRITE  = 1,
  parameter int unsigned PAR_READ   = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0]   in_data,
  output logic                              in_ready,
  input  logic                              updateRP,
  output logic                              buf_wen,
  output logic [ptr_w(COLUMNS)-1:0]         buf_waddr,
  output logic [PAR_WRITE*DATA_WIDTH-1:0]   buf_wdata,
  output logic [ptr_w(COLUMNS)-1:0]         write_ptr_out,
  output logic [cnt_w(COLUMNS)-1:0]         occupancy,
  output logic                              full,
  output logic                              empty,
  output logic                              read_avail,
  output logic                              underflow_err
);

  localparam int unsigned PTR_W = ptr_w(COLUMNS);
  localparam int unsigned CNT_W = cnt_w(COLUMNS);
  localparam int unsigned DW    = PAR_WRITE * DATA_WIDTH;

  logic             stage_valid_q, stage_valid_d;
  logic [DW-1:0]    stage_data_q,  stage_data_d;
  logic [CNT_W-1:0] occupancy_q,   occupancy_d;
  logic             underflow_q,   underflow_d;

  logic             commit;
  logic             accept;
  logic             read_ok;
  logic [PTR_W-1:0] wptr;

  // Status decodes use registered occupancy only, so there is no path from updateRP to a commit
  assign full       = occupancy_q > CNT_W'(COLUMNS - PAR_WRITE);
  assign empty      = occupancy_q == '0;
  assign read_avail = occupancy_q >= CNT_W'(PAR_READ);

  // Reset cycle suppresses the commit so staged data is discarded, not written
  assign commit   = stage_valid_q && !full && !rst;
  assign in_ready = !stage_valid_q || commit;
  assign accept   = in_valid && in_ready;
  assign read_ok  = updateRP && read_avail;

  write_ptr_update #(
    .COLUMNS  (COLUMNS),
    .PAR_WRITE(PAR_WRITE)
  ) u_write_ptr (
    .clk          (clk),
    .rst          (rst),
    .updateWP     (commit),
    .write_ptr_out(wptr)
  );

  // Stage, occupancy and error next-state
  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_data_d  = stage_data_q;
    occupancy_d   = occupancy_q;
    underflow_d   = underflow_q;

    if (accept) begin
      stage_valid_d = 1'b1;
      stage_data_d  = in_data;
    end else if (commit) begin
      stage_valid_d = 1'b0;
    end

    // Both deltas apply in one expression so a simultaneous commit and read net out
    occupancy_d = occupancy_q
                + (commit  ? CNT_W'(PAR_WRITE) : CNT_W'(0))
                - (read_ok ? CNT_W'(PAR_READ)  : CNT_W'(0));

    if (updateRP && !read_ok) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      occupancy_q   <= '0;
      underflow_q   <= 1'b0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      occupancy_q   <= occupancy_d;
      underflow_q   <= underflow_d;
    end
  end

  assign buf_wen       = commit;
  assign buf_waddr     = wptr;
  assign buf_wdata     = stage_data_q;
  assign write_ptr_out = wptr;
  assign occupancy     = occupancy_q;
  assign underflow_err = underflow_q;

endmodule
